// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, fetches words over req/ack and
// hands {pc, instr, fault} to decode through a single-entry IF/ID register.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int unsigned XLEN = 64,
  localparam int unsigned ILEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            imem_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  output logic            if_inv_addr
);

  typedef enum logic [1:0] {RUN, KILL, HALT} state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            inv_addr;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] kill_addr_q, kill_addr_d;
  entry_t          entry_q, entry_d;

  logic accept;
  logic aligned;

  assign accept  = !entry_q.valid || id_ready;
  assign aligned = (pc_q[1:0] == 2'b00);

  // A squashed request keeps presenting its original address until it is acked
  assign imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;

  // Request only while out of reset; RUN holds the slot free so req stays stable
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      RUN:     imem_req = accept && aligned;
      KILL:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
    imem_req = imem_req && reset_n;
  end

  // Next-state, PC and output-entry update; redirect overrides everything
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    entry_d     = entry_q;

    if (entry_q.valid && id_ready) begin
      entry_d.valid = 1'b0;
    end

    if (redirect_valid) begin
      pc_d          = redirect_pc;
      entry_d.valid = 1'b0;
      if (imem_req && !imem_ack) begin
        state_d = KILL;
        if (state_q != KILL) begin
          kill_addr_d = pc_q;
        end
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (imem_req && imem_ack) begin
            entry_d.valid    = 1'b1;
            entry_d.pc       = pc_q;
            entry_d.instr    = imem_err ? NOP_INSTR : imem_rdata;
            entry_d.inv_addr = imem_err;
            if (imem_err) begin
              state_d = HALT;
            end else begin
              pc_d = pc_q + XLEN'(4);
            end
          end else if (accept && !aligned) begin
            entry_d.valid    = 1'b1;
            entry_d.pc       = pc_q;
            entry_d.instr    = NOP_INSTR;
            entry_d.inv_addr = 1'b1;
            state_d          = HALT;
          end
        end
        KILL: begin
          if (imem_ack) begin
            state_d = RUN;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // State, PC and IF/ID register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      kill_addr_q <= '0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      entry_q     <= entry_d;
    end
  end

  assign if_valid    = entry_q.valid;
  assign if_pc       = entry_q.pc;
  assign if_instr    = entry_q.instr;
  assign if_inv_addr = entry_q.inv_addr;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random memory latency, backpressure,
// redirects and faults against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_inv_addr;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_inv_addr(if_inv_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        inv;
  } exp_t;

  exp_t        q[$];
  int unsigned vec = 0;
  int unsigned errs = 0;
  int unsigned n_consumed = 0;

  // Stimulus knobs
  int unsigned lat_min = 0, lat_max = 0;
  int unsigned ready_pct = 100, redir_pct = 0, err_pct = 0;
  logic [63:0] err_addr = '1;
  bit          force_redir = 1'b0;
  logic [63:0] force_pc = '0;

  // Memory model state
  bit          mem_busy = 1'b0;
  int unsigned mem_wait = 0;
  logic [63:0] mem_addr = '0;

  // Reference model state
  logic [63:0] m_pc, m_kadr;
  bit          m_kill, m_halt;
  bit          cyc_accept, cyc_exp_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand_target();
    int unsigned r;
    logic [63:0] t;
    r = $urandom_range(9, 0);
    t = 64'({$urandom()});
    if (r == 0)      rand_target = {t[63:2], 2'b10};
    else if (r == 1) rand_target = 64'hFFFF_FFFF_FFFF_FFF0;
    else             rand_target = t & ~64'h3;
  endfunction

  task automatic check_reset();
    chk("rst_imem_req",  64'(imem_req), 64'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid",  64'(if_valid), 64'd0);
    chk("rst_if_pc",     if_pc, 64'd0);
    chk("rst_if_instr",  64'(if_instr), 64'd0);
    chk("rst_if_inv",    64'(if_inv_addr), 64'd0);
  endtask

  task automatic redirect_to(input logic [63:0] t);
    @(posedge clock);
    force_pc    = t;
    force_redir = 1'b1;
  endtask

  // Driver: decode/execute side at +1, memory responds at +2
  always begin
    @(posedge clock);
    #1;
    if (!reset_n) begin
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
    end else begin
      id_ready = ($urandom_range(99, 0) < ready_pct);
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_pc;
        force_redir    = 1'b0;
      end else if ($urandom_range(99, 0) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = rand_target();
      end else begin
        redirect_valid = 1'b0;
      end
    end
    #1;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = $urandom();
    if (!reset_n) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) begin
        chk("req_held", 64'(imem_req), 64'd1);
        if (imem_req) chk("addr_stable", imem_addr, mem_addr);
      end
      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = $urandom_range(lat_max, lat_min);
          mem_addr = imem_addr;
        end
        if (mem_wait == 0) begin
          imem_ack = 1'b1;
          imem_err = (imem_addr == err_addr) || ($urandom_range(99, 0) < err_pct);
          mem_busy = 1'b0;
        end else begin
          mem_wait--;
        end
      end
    end
  end

  // Monitor: compare outputs against the model and pop on consume
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      cyc_accept  = (q.size() == 0) || id_ready;
      cyc_exp_req = m_kill || (!m_halt && cyc_accept && (m_pc[1:0] == 2'b00));
      chk("if_valid", 64'(if_valid), 64'(q.size() != 0));
      chk("imem_req", 64'(imem_req), 64'(cyc_exp_req));
      if (imem_req) chk("imem_addr", imem_addr, m_kill ? m_kadr : m_pc);
      if (redirect_valid) begin
        q.delete();
      end else if (if_valid && id_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", 64'(if_instr), 64'(e.instr));
        chk("if_inv_addr", 64'(if_inv_addr), 64'(e.inv));
        n_consumed++;
      end
    end
  end

  // Reference model: program-order fetch stream with squash and halt rules
  always @(posedge clock) begin
    if (!reset_n) begin
      m_pc   = RESET_PC;
      m_kadr = '0;
      m_kill = 1'b0;
      m_halt = 1'b0;
      q.delete();
    end else if (redirect_valid) begin
      if (cyc_exp_req && !imem_ack) begin
        if (!m_kill) m_kadr = m_pc;
        m_kill = 1'b1;
      end else begin
        m_kill = 1'b0;
      end
      m_pc   = redirect_pc;
      m_halt = 1'b0;
    end else if (m_kill) begin
      if (imem_ack) m_kill = 1'b0;
    end else if (!m_halt) begin
      if (imem_ack) begin
        if (imem_err) begin
          q.push_back('{pc: m_pc, instr: NOP, inv: 1'b1});
          m_halt = 1'b1;
        end else begin
          q.push_back('{pc: m_pc, instr: imem_rdata, inv: 1'b0});
          m_pc = m_pc + 64'd4;
        end
      end else if (cyc_accept && m_pc[1:0] != 2'b00) begin
        q.push_back('{pc: m_pc, instr: NOP, inv: 1'b1});
        m_halt = 1'b1;
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_err       = 1'b0;
    imem_rdata     = '0;
    repeat (2) @(posedge clock);
    #3 check_reset();
    @(posedge clock);
    #3 reset_n = 1'b1;

    // Zero-wait streaming, then backpressure
    repeat (20) @(posedge clock);
    ready_pct = 50;
    repeat (40) @(posedge clock);
    ready_pct = 100;

    // Misaligned target halts until a good redirect
    redirect_to(64'h102);
    repeat (8) @(posedge clock);
    redirect_to(64'h200);
    repeat (8) @(posedge clock);

    // Memory error halts fetch
    err_addr = 64'h40;
    redirect_to(64'h38);
    repeat (8) @(posedge clock);
    err_addr = '1;

    // PC wrap at the top of the address space
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    repeat (8) @(posedge clock);

    // Redirect in the first cycle of a slow request -> kill
    redirect_to(64'h102);
    repeat (4) @(posedge clock);
    lat_min = 2;
    lat_max = 2;
    redirect_to(64'h80);
    redirect_to(64'h100);
    repeat (15) @(posedge clock);

    // Fully random with occasional mid-run reset
    lat_min   = 0;
    lat_max   = 3;
    ready_pct = 70;
    redir_pct = 8;
    err_pct   = 3;
    for (int r = 0; r < 3; r++) begin
      repeat (1500) @(posedge clock);
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1 check_reset();
      @(posedge clock);
      #3 reset_n = 1'b1;
    end
    repeat (200) @(posedge clock);

    chk("progress", 64'(n_consumed >= 300), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
